// File: rtl/insn_encoder.sv
// Encodes a cluster/variant request with register and immediate operands into a
// big-endian PowerPC instruction word and queues it in a 2-entry output FIFO.
module insn_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cluster,
  input  logic [1:0]  req_sel,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_ra,
  input  logic [4:0]  req_rb,
  input  logic [15:0] req_imm,
  output logic [0:31] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        err_illegal,
  output logic [7:0]  illegal_cnt,
  output logic [15:0] emit_cnt
);

  // D-form: OPCD | RT | RA | 16-bit immediate.
  function automatic logic [31:0] d_form(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] ra, input logic [15:0] imm);
    return {op, rt, ra, imm};
  endfunction

  // X/XL-form: OPCD | RT | RA | RB | XO | Rc(=0).
  function automatic logic [31:0] x_form(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] ra, input logic [4:0] rb,
                                         input logic [9:0] xo);
    return {op, rt, ra, rb, xo, 1'b0};
  endfunction

  localparam logic [5:0] OpX = 6'd31;

  logic [31:0] word;
  logic [9:0]  spr;
  logic        legal;
  logic        accept, push, pop, illegal_acc;

  logic [31:0] mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        err_q;
  logic [7:0]  illegal_cnt_q;
  logic [15:0] emit_cnt_q;

  // Combinational encoder for the current request.
  always_comb begin
    word  = '0;
    // SPR number goes in with its two 5-bit halves swapped.
    spr   = {req_imm[4:0], req_imm[9:5]};
    legal = ~req_cluster[3];
    case (req_cluster)
      4'd0: case (req_sel)
        2'd0: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd266);
        2'd1: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd40);
        2'd2: word = d_form(6'd14, req_rt, req_ra, req_imm);
        2'd3: word = d_form(6'd15, req_rt, req_ra, req_imm);
      endcase
      4'd1: case (req_sel)
        2'd0: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd28);
        2'd1: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd444);
        2'd2: word = d_form(6'd24, req_rt, req_ra, req_imm);
        2'd3: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd316);
      endcase
      4'd2: case (req_sel)
        2'd0: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd235);
        2'd1: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd75);
        2'd2: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd491);
        2'd3: word = d_form(6'd7, req_rt, req_ra, req_imm);
      endcase
      4'd3: case (req_sel)
        2'd0: word = d_form(6'd32, req_rt, req_ra, req_imm);
        2'd1: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd23);
        2'd2: word = d_form(6'd34, req_rt, req_ra, req_imm);
        2'd3: word = d_form(6'd40, req_rt, req_ra, req_imm);
      endcase
      4'd4: case (req_sel)
        2'd0: word = d_form(6'd36, req_rt, req_ra, req_imm);
        2'd1: word = x_form(OpX, req_rt, req_ra, req_rb, 10'd151);
        2'd2: word = d_form(6'd38, req_rt, req_ra, req_imm);
        2'd3: word = d_form(6'd44, req_rt, req_ra, req_imm);
      endcase
      4'd5: case (req_sel)
        2'd0: word = d_form(6'd33, req_rt, req_ra, req_imm);
        2'd1: word = d_form(6'd37, req_rt, req_ra, req_imm);
        2'd2: word = d_form(6'd35, req_rt, req_ra, req_imm);
        2'd3: word = d_form(6'd39, req_rt, req_ra, req_imm);
      endcase
      4'd6: case (req_sel)
        2'd0: word = {6'd18, {8{req_imm[15]}}, req_imm, 2'b00};
        2'd1: word = {6'd16, req_rt, req_ra, req_imm[13:0], 2'b00};
        2'd2: word = x_form(6'd19, req_rt, req_ra, 5'd0, 10'd16);
        2'd3: word = x_form(6'd19, req_rt, req_ra, 5'd0, 10'd528);
      endcase
      4'd7: case (req_sel)
        2'd0: word = x_form(OpX, req_rt, spr[9:5], spr[4:0], 10'd339);
        2'd1: word = x_form(OpX, req_rt, 5'd0, 5'd0, 10'd83);
        2'd2: word = x_form(OpX, req_rt, 5'd0, 5'd0, 10'd19);
        2'd3: word = x_form(OpX, req_rt, spr[9:5], spr[4:0], 10'd467);
      endcase
      default: word = '0;
    endcase
  end

  // Handshake decode and FIFO occupancy next-state.
  always_comb begin
    req_ready   = (count_q != 2'd2);
    instr_valid = (count_q != 2'd0);
    accept      = req_valid & req_ready;
    push        = accept & legal;
    illegal_acc = accept & ~legal;
    pop         = instr_valid & instr_ready;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Error pulse and statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q         <= 1'b0;
      illegal_cnt_q <= 8'd0;
      emit_cnt_q    <= 16'd0;
    end else begin
      err_q <= illegal_acc;
      if (illegal_acc && illegal_cnt_q != 8'hFF) begin
        illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end
      if (pop) begin
        emit_cnt_q <= emit_cnt_q + 16'd1;
      end
    end
  end

  // Head word is forced to zero while the buffer is empty.
  always_comb begin
    instr       = instr_valid ? mem_q[rd_ptr_q] : 32'd0;
    err_illegal = err_q;
    illegal_cnt = illegal_cnt_q;
    emit_cnt    = emit_cnt_q;
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder with a queue-based reference model.
module tb_insn_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cluster = '0;
  logic [1:0]  req_sel = '0;
  logic [4:0]  req_rt = '0, req_ra = '0, req_rb = '0;
  logic [15:0] req_imm = '0;
  logic [0:31] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        err_illegal;
  logic [7:0]  illegal_cnt;
  logic [15:0] emit_cnt;

  int checks = 0;
  int errors = 0;

  insn_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cluster (req_cluster),
    .req_sel     (req_sel),
    .req_rt      (req_rt),
    .req_ra      (req_ra),
    .req_rb      (req_rb),
    .req_imm     (req_imm),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .err_illegal (err_illegal),
    .illegal_cnt (illegal_cnt),
    .emit_cnt    (emit_cnt)
  );

  always #5 clk = ~clk;

  // Mnemonic tables for clusters 0..5: D-form primary opcode (0 = X-form) and XO.
  int unsigned dop [24] = '{0, 0, 14, 15,  0, 0, 24, 0,  0, 0, 0, 7,
                            32, 0, 34, 40,  36, 0, 38, 44,  33, 37, 35, 39};
  int unsigned xop [24] = '{266, 40, 0, 0,  28, 444, 0, 316,  235, 75, 491, 0,
                            0, 23, 0, 0,  0, 151, 0, 0,  0, 0, 0, 0};

  function automatic logic [31:0] enc(int unsigned cl, int unsigned sel, int unsigned rt,
                                      int unsigned ra, int unsigned rb, int unsigned imm);
    int unsigned k, li, spr;
    k = cl * 4 + sel;
    if (cl < 6) begin
      if (dop[k] != 0) return 32'(dop[k] * 2**26 + rt * 2**21 + ra * 2**16 + imm);
      return 32'(31 * 2**26 + rt * 2**21 + ra * 2**16 + rb * 2**11 + xop[k] * 2);
    end
    if (cl == 6) begin
      li = (imm >= 32768) ? imm + 16777216 - 65536 : imm;
      case (sel)
        0: return 32'(18 * 2**26 + li * 4);
        1: return 32'(16 * 2**26 + rt * 2**21 + ra * 2**16 + (imm % 16384) * 4);
        2: return 32'(19 * 2**26 + rt * 2**21 + ra * 2**16 + 16 * 2);
        default: return 32'(19 * 2**26 + rt * 2**21 + ra * 2**16 + 528 * 2);
      endcase
    end
    spr = (imm % 32) * 32 + (imm / 32) % 32;
    case (sel)
      0: return 32'(31 * 2**26 + rt * 2**21 + spr * 2**11 + 339 * 2);
      1: return 32'(31 * 2**26 + rt * 2**21 + 83 * 2);
      2: return 32'(31 * 2**26 + rt * 2**21 + 19 * 2);
      default: return 32'(31 * 2**26 + rt * 2**21 + spr * 2**11 + 467 * 2);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, counters as plain integers.
  logic [31:0] mq [$];
  int          m_ill = 0;
  logic [15:0] m_emit = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ill  <= 0;
      m_emit <= '0;
      m_err  <= 1'b0;
    end else begin
      bit acc, do_pop;
      acc    = req_valid && (mq.size() < 2);
      do_pop = (mq.size() != 0) && instr_ready;
      m_err <= acc && (req_cluster >= 8);
      if (acc && req_cluster >= 8 && m_ill < 255) m_ill <= m_ill + 1;
      if (do_pop) begin
        void'(mq.pop_front());
        m_emit <= m_emit + 16'd1;
      end
      if (acc && req_cluster < 8)
        mq.push_back(enc(req_cluster, req_sel, req_rt, req_ra, req_rb, req_imm));
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_valid", 32'(instr_valid), 32'(mq.size() != 0));
    chk("m_instr", instr, (mq.size() != 0) ? mq[0] : 32'd0);
    chk("m_ready", 32'(req_ready), 32'(mq.size() < 2));
    chk("m_err", 32'(err_illegal), 32'(m_err));
    chk("m_illcnt", 32'(illegal_cnt), 32'(m_ill));
    chk("m_emit", 32'(emit_cnt), 32'(m_emit));
  end

  // Drive a request at a falling edge; return at the falling edge after acceptance.
  task automatic send(input int cl, input int sel, input int rt, input int ra, input int rb,
                      input int imm);
    req_cluster = 4'(cl);
    req_sel     = 2'(sel);
    req_rt      = 5'(rt);
    req_ra      = 5'(ra);
    req_rb      = 5'(rb);
    req_imm     = 16'(imm);
    req_valid   = 1'b1;
    for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
    if (!req_ready) begin
      errors++;
      $display("FAIL send_timeout actual=req_ready 0 expected=req_ready 1 at %0t", $time);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Pin the model against hand-computed words.
    chk("model_add", enc(0, 0, 3, 4, 5, 0), 32'h7C642A14);
    chk("model_addi", enc(0, 2, 1, 1, 0, 16'hFFF0), 32'h3821FFF0);
    chk("model_b", enc(6, 0, 0, 0, 0, 16'hFFFF), 32'h4BFFFFFC);
    chk("model_mfmsr", enc(7, 1, 5, 0, 0, 0), 32'h7CA000A6);
    chk("model_mfspr", enc(7, 0, 3, 0, 0, 8), 32'h7C6802A6);

    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    // Basic encodes with the consumer always ready.
    instr_ready = 1'b1;
    send(0, 0, 3, 4, 5, 0);
    chk("add", instr, 32'h7C642A14);
    send(0, 2, 1, 1, 0, 16'hFFF0);
    chk("addi", instr, 32'h3821FFF0);
    send(3, 0, 9, 1, 0, 8);
    chk("lwz", instr, 32'h81210008);
    send(6, 0, 0, 0, 0, 16'hFFFF);
    chk("b", instr, 32'h4BFFFFFC);
    send(7, 1, 5, 0, 0, 0);
    chk("mfmsr", instr, 32'h7CA000A6);
    send(7, 0, 3, 0, 0, 8);
    chk("mfspr", instr, 32'h7C6802A6);

    // Sweep every legal cluster/variant with a varying consumer.
    for (int cl = 0; cl < 8; cl++) begin
      for (int sel = 0; sel < 4; sel++) begin
        instr_ready = ((cl + sel) % 3 != 0);
        if (!req_ready) instr_ready = 1'b1;
        send(cl, sel, (cl * 7 + sel) % 32, (cl * 3 + sel * 5 + 1) % 32,
             (cl + sel * 11 + 2) % 32, (cl * 4099 + sel * 12345 + 'h8421) % 65536);
      end
    end
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Backpressure: three requests offered while the consumer stalls.
    do_reset();
    instr_ready = 1'b0;
    req_valid = 1'b1;
    req_cluster = 4'd0; req_sel = 2'd0; req_rt = 5'd3; req_ra = 5'd4; req_rb = 5'd5;
    @(negedge clk);
    req_cluster = 4'd0; req_sel = 2'd2; req_rt = 5'd1; req_ra = 5'd1; req_imm = 16'hFFF0;
    @(negedge clk);
    req_cluster = 4'd3; req_sel = 2'd0; req_rt = 5'd9; req_ra = 5'd1; req_imm = 16'd8;
    @(negedge clk);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_hold", instr, 32'h7C642A14);
    @(negedge clk);
    chk("bp_hold2", instr, 32'h7C642A14);
    req_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_second", instr, 32'h3821FFF0);
    @(negedge clk);
    chk("bp_empty", 32'(instr_valid), 32'd0);
    chk("bp_emit", 32'(emit_cnt), 32'd2);

    // Push and pop together at one buffered entry.
    instr_ready = 1'b0;
    send(0, 0, 3, 4, 5, 0);
    instr_ready = 1'b1;
    send(0, 2, 1, 1, 0, 16'hFFF0);
    chk("pp_head", instr, 32'h3821FFF0);
    chk("pp_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("pp_drained", 32'(instr_valid), 32'd0);

    // Illegal cluster.
    send(9, 0, 1, 2, 3, 4);
    chk("ill_pulse", 32'(err_illegal), 32'd1);
    chk("ill_cnt", 32'(illegal_cnt), 32'd1);
    chk("ill_noenq", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("ill_pulse_end", 32'(err_illegal), 32'd0);

    // Asynchronous reset with two words buffered.
    instr_ready = 1'b0;
    send(1, 1, 2, 3, 4, 0);
    send(2, 3, 5, 6, 0, 100);
    chk("mr_full", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_instr", instr, 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("mr_illcnt", 32'(illegal_cnt), 32'd0);
    chk("mr_emit", 32'(emit_cnt), 32'd0);

    // Saturation of the illegal counter.
    req_cluster = 4'd12;
    req_valid = 1'b1;
    repeat (300) @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("ill_sat", 32'(illegal_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
